serial_alu_seq: RTL and testbench
=================================

Name: serial_alu_seq

Overview:
- Multi-cycle add/subtract sequencer for the ALU.
- Reuses a single 1-bit full-adder slice, built from two half adders, over a WIDTH-bit operand, LSB first, one bit per clock.
- Produces the sum/difference and the ZF/SF/OF condition codes for addq/subq.
- Uses a start/busy/done handshake so the execute-stage control can stall on it.

Parameters:
- WIDTH, 64, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = add, 1 = subtract (a - b).
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when outputs become valid.
- result  output  WIDTH  sum/difference.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- zf  output  1  result == 0.
- sf  output  1  result[WIDTH-1].
- of  output  1  signed overflow.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state = IDLE; bit counter = 0; carry = 0.
  - result, cout, zf, sf, of, busy, done all 0.
  - Applies in any state; an in-flight operation is aborted with no done pulse.
- IDLE:
  - start = 1 latches a into shift register A and (op ? ~b : b) into shift register B.
  - carry is loaded with op; counter is cleared; next state is RUN.
  - start = 0 leaves all outputs held.
- RUN (exactly WIDTH cycles):
  - Each cycle the slice computes s = A[0]^B[0]^carry and c' = majority(A[0], B[0], carry).
  - s shifts into the result register from the MSB side; A and B shift right; carry <= c'.
  - On the cycle where counter == WIDTH-1, the pre-update carry is saved as cin_msb.
  - After that cycle the next state is DONE.
  - The result register is internal during RUN. The result output port holds its previous value until DONE.
- DONE (1 cycle):
  - result, cout = carry, zf, sf and of = cin_msb ^ carry update together.
  - done = 1 for exactly this cycle; next state is IDLE.
- Latency: start seen at edge N → done high in the cycle after edge N+WIDTH+1 → next start accepted at edge N+WIDTH+2. Throughput is one op per WIDTH+2 cycles.
- start while busy: ignored, not queued. The operand inputs are don't-care outside the start cycle.
- Outputs are held from DONE until the next DONE or reset. A new start does not clear them.
- busy is registered: 0 in IDLE, 1 in RUN and DONE.
- Subtract cout follows x86/y86 two's-complement convention: cout = 1 when a >= b unsigned. Downstream inverts it for a borrow flag if needed.
- No X propagation: every register has an explicit reset or load value.

Decomposition:
- Shared package/header alu_pkg:
  - state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - op constants: ALU_ADD = 1'b0, ALU_SUB = 1'b1.
  - default WIDTH = 64.
- One sub-module, fa_bit (inputs x, y, cin; outputs s, cout), built from two half_adder instances plus an OR. It is instantiated once in the datapath.
- FSM, counter and shift registers stay in serial_alu_seq.

Test Plan:
1. op = 0, a = 5, b = 3, start for 1 cycle → done exactly 65 cycles after the start edge; result = 8, cout = 0, zf = 0, sf = 0, of = 0; busy high for 65 cycles.
2. op = 1, a = 7, b = 7 → result = 0, zf = 1, sf = 0, cout = 1, of = 0. Repeat with a = 3, b = 5 → result = 0xFFFF_FFFF_FFFF_FFFE, sf = 1, cout = 0, of = 0.
3. op = 0, a = 0x7FFF_FFFF_FFFF_FFFF, b = 1 → result = 0x8000_0000_0000_0000, sf = 1, of = 1, cout = 0. Then op = 0, a = 0xFFFF_FFFF_FFFF_FFFF, b = 1 → result = 0, zf = 1, cout = 1, of = 0.
4. Start add 5+3; on RUN cycle 10, pulse start with op = 1, a = 100, b = 1 → ignored; single done with result = 8; next start is accepted only after done.
5. rst_n low for 1 cycle at RUN cycle 20 → next cycle busy = 0, done = 0, all outputs 0; no done pulse follows; a fresh start of 2+2 yields result = 4 after 65 cycles.
6. Back-to-back: start held high continuously with op = 0, a = 1, b = 1 → done every 66 cycles, result = 2 each time; outputs held stable between done pulses.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding, op codes and default width for the serial ALU.
package alu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;
  localparam int DEF_WIDTH = 64;
endpackage

// File: rtl/serial_alu_seq_if.sv
// serial_alu_seq_if: start/busy/done handshake, operands and condition-code results.
interface serial_alu_seq_if #(parameter int WIDTH = alu_pkg::DEF_WIDTH);
  logic start;
  logic op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
  logic cout;
  logic zf;
  logic sf;
  logic of;
  modport master(output start, op, a, b, input busy, done, result, cout, zf, sf, of);
  modport slave(input start, op, a, b, output busy, done, result, cout, zf, sf, of);
endinterface

// File: rtl/fa_bit.sv
// fa_bit: one-bit full adder built from two half adders and an OR.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic w_s1, w_c1, w_c2;
  half_adder u_ha0 (.x(x),    .y(y),   .s(w_s1), .c(w_c1));
  half_adder u_ha1 (.x(w_s1), .y(cin), .s(s),    .c(w_c2));
  assign cout = w_c1 | w_c2;
endmodule

// File: rtl/half_adder.sv
// half_adder: one-bit sum and carry of two inputs.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial add/subtract, LSB first, with ZF/SF/OF/carry flags.
module serial_alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst_n,
  serial_alu_seq_if.slave bus
);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic r_carry, r_cin_msb, r_busy, r_done, r_cout, r_zf, r_sf, r_of;
  logic w_s, w_c, w_last, w_load, w_shift, w_fin;
  fa_bit u_fa (.x(r_a[0]), .y(r_b[0]), .cin(r_carry), .s(w_s), .cout(w_c));
  assign w_last = r_cnt == CNT_W'(WIDTH - 1);
  always_ff @(posedge clk) begin
    r_state <= !rst_n ? IDLE : w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE) ? (bus.start ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
  end
  always_comb begin
    w_load  = (r_state == IDLE) && bus.start;
    w_shift = r_state == RUN;
    w_fin   = r_state == DONE;
  end
  // Subtract is a + ~b + 1: B is inverted on load and the carry seeded with 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_cin_msb <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cout    <= 1'b0;
      r_zf      <= 1'b0;
      r_sf      <= 1'b0;
      r_of      <= 1'b0;
    end else begin
      r_busy <= w_next != IDLE;
      r_done <= w_fin;
      if (w_load) begin
        r_a     <= bus.a;
        r_b     <= (bus.op == ALU_SUB) ? ~bus.b : bus.b;
        r_carry <= bus.op == ALU_SUB;
        r_cnt   <= '0;
      end
      if (w_shift) begin
        r_acc   <= {w_s, r_acc[WIDTH-1:1]};
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_carry <= w_c;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) r_cin_msb <= r_carry;
      end
      if (w_fin) begin
        r_result <= r_acc;
        r_cout   <= r_carry;
        r_zf     <= r_acc == '0;
        r_sf     <= r_acc[WIDTH-1];
        r_of     <= r_cin_msb ^ r_carry;
      end
    end
  end
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.zf     = r_zf;
  assign bus.sf     = r_sf;
  assign bus.of     = r_of;
endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: directed and random checks of serial_alu_seq against an arithmetic model.
module tb_serial_alu_seq;
  import alu_pkg::*;
  localparam int W = 64;
  typedef struct packed {
    logic [W-1:0] res;
    logic cout;
    logic zf;
    logic sf;
    logic of;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic m_act = 1'b0;
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  int m_dcyc = 0;
  exp_t m_pend = '0;
  exp_t m_out = '0;
  always #5 clk = ~clk;
  serial_alu_seq_if #(.WIDTH(W)) bus ();
  serial_alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic exp_t calc(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic signed [W:0] sv;
    logic [W:0] uv;
    uv = (op == ALU_SUB) ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
    sv = (op == ALU_SUB) ? $signed({x[W-1], x}) - $signed({y[W-1], y})
                         : $signed({x[W-1], x}) + $signed({y[W-1], y});
    e.res  = uv[W-1:0];
    e.cout = (op == ALU_SUB) ? (x >= y) : uv[W];
    e.zf   = e.res == '0;
    e.sf   = e.res[W-1];
    e.of   = sv[W] != sv[W-1];
    return e;
  endfunction
  function automatic logic [W+3:0] outs();
    return {bus.result, bus.cout, bus.zf, bus.sf, bus.of};
  endfunction
  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    v = {$urandom(), $urandom()};
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = {1'b0, {(W-1){1'b1}}};
      3: v = {1'b1, {(W-1){1'b0}}};
      4: v = W'($urandom_range(0, 15));
      default: ;
    endcase
    return v;
  endfunction
  // Model: an accepted op finishes W+1 edges later; starts while busy are dropped.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_act  <= 1'b0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_out  <= '0;
    end else if (m_act && cyc == m_dcyc) begin
      m_act  <= 1'b0;
      m_busy <= 1'b0;
      m_done <= 1'b1;
      m_out  <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (!m_act && bus.start) begin
        m_act  <= 1'b1;
        m_busy <= 1'b1;
        m_dcyc <= cyc + W + 1;
        m_pend <= calc(bus.op, bus.a, bus.b);
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en)
      chk("model", {bus.busy, bus.done, bus.cout, bus.zf, bus.sf, bus.of, bus.result},
          {m_busy, m_done, m_out.cout, m_out.zf, m_out.sf, m_out.of, m_out.res});
  end
  task automatic go(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = x;
    bus.b = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = {$urandom(), $urandom()};
    bus.b = {$urandom(), $urandom()};
  endtask
  task automatic wait_done(output int lat, output int nb);
    lat = 0;
    nb = 0;
    while (!bus.done && lat < 300) begin
      if (bus.busy) nb++;
      @(negedge clk);
      lat++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask
  task automatic count_dones(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) c++;
    end
  endtask
  initial begin
    int lat, nb, c;
    bus.start = 1'b0;
    bus.op = ALU_ADD;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_outs", {bus.busy, bus.done, outs()}, '0);
    chk_en = 1'b1;
    go(ALU_ADD, 64'd5, 64'd3);
    wait_done(lat, nb);
    chk("t1_latency", lat, 65);
    chk("t1_busy_cycles", nb, 65);
    chk("t1_out", outs(), {64'd8, 4'b0000});
    go(ALU_SUB, 64'd7, 64'd7);
    wait_done(lat, nb);
    chk("t2_eq", outs(), {64'd0, 4'b1100});
    go(ALU_SUB, 64'd3, 64'd5);
    wait_done(lat, nb);
    chk("t2_neg", outs(), {64'hFFFF_FFFF_FFFF_FFFE, 4'b0010});
    go(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    wait_done(lat, nb);
    chk("t3_ovf", outs(), {64'h8000_0000_0000_0000, 4'b0011});
    go(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    wait_done(lat, nb);
    chk("t3_wrap", outs(), {64'd0, 4'b1100});
    go(ALU_ADD, 64'd5, 64'd3);
    repeat (9) @(negedge clk);
    go(ALU_SUB, 64'd100, 64'd1);
    wait_done(lat, nb);
    chk("t4_ignored", outs(), {64'd8, 4'b0000});
    count_dones(70, c);
    chk("t4_single_done", c, 0);
    go(ALU_SUB, 64'd9, 64'd9);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_reset_outs", {bus.busy, bus.done, outs()}, '0);
    count_dones(80, c);
    chk("t5_no_done", c, 0);
    go(ALU_ADD, 64'd2, 64'd2);
    wait_done(lat, nb);
    chk("t5_latency", lat, 65);
    chk("t5_out", outs(), {64'd4, 4'b0000});
    bus.start = 1'b1;
    bus.op = ALU_ADD;
    bus.a = 64'd1;
    bus.b = 64'd1;
    @(negedge clk);
    wait_done(lat, nb);
    chk("t6_first", outs(), {64'd2, 4'b0000});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wait_done(lat, nb);
      chk("t6_interval", lat + 1, 66);
      chk("t6_out", outs(), {64'd2, 4'b0000});
    end
    bus.start = 1'b0;
    c = 0;
    repeat (3000) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.op = 1'($urandom_range(0, 1));
      bus.a = pick();
      bus.b = pick();
      @(negedge clk);
      if (bus.done) c++;
    end
    bus.start = 1'b0;
    repeat (70) @(negedge clk);
    chk("rand_done_count_ok", c >= 20, 1);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
